// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared receiver state encoding and word width constant
package serial_pkg;

  // Word width shared with the transmitter side
  localparam int SERIAL_DATA_W = 8;

  // Receiver states; PARITY is only reachable when SERIAL_RX_PARITY_EN is defined
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-stage input synchronizer with rising-edge detect
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the synchronizer chain and keep one more delayed copy for edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - framed MSB-first serial receiver; optional even parity via SERIAL_RX_PARITY_EN
module serial_rx
  import serial_pkg::*;
#(
  parameter int DATA_W      = SERIAL_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              transmission,
  input  logic              clock,
  input  logic              data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic t_s, d_s, sclk_rise;
  logic csync_unused, t_rise_unused, d_rise_unused;

  rx_state_t state, next_state;

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] word_next;
  logic [CNT_W-1:0]  cnt;

  logic start, shift_en, word_done, abort_err, load_word, err_pulse;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_t (
    .clk(clk), .rst(rst), .din(transmission), .dout(t_s), .rise(t_rise_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_c (
    .clk(clk), .rst(rst), .din(clock), .dout(csync_unused), .rise(sclk_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_d (
    .clk(clk), .rst(rst), .din(data), .dout(d_s), .rise(d_rise_unused)
  );

  assign word_next = {shreg[DATA_W-2:0], d_s};

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; a transmission fall always takes priority over a serial clock edge
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (t_s) next_state = SHIFT;
      SHIFT: begin
        if (!t_s) next_state = IDLE;
`ifdef SERIAL_RX_PARITY_EN
        else if (word_done) next_state = PARITY;
`endif
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (!t_s)           next_state = IDLE;
        else if (sclk_rise) next_state = SHIFT;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Per-cycle control decodes driving the datapath and output pulses
  always_comb begin
    start     = (state == IDLE) && t_s;
    shift_en  = (state == SHIFT) && t_s && sclk_rise;
    word_done = shift_en && (cnt == LAST_BIT);
    abort_err = (state == SHIFT) && !t_s && (cnt != '0);
`ifdef SERIAL_RX_PARITY_EN
    load_word = (state == PARITY) && t_s && sclk_rise && !(^shreg ^ d_s);
    err_pulse = abort_err || ((state == PARITY) && !t_s) ||
                ((state == PARITY) && t_s && sclk_rise && (^shreg ^ d_s));
`else
    load_word = word_done;
    err_pulse = abort_err;
`endif
  end

  // Shift register, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg     <= '0;
      cnt       <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load_word;
      frame_err <= err_pulse;
      if (load_word) begin
`ifdef SERIAL_RX_PARITY_EN
        rx_data <= shreg;
`else
        rx_data <= word_next;
`endif
      end
      if (start) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (abort_err) begin
        cnt <= '0;
      end else if (shift_en) begin
        shreg <= word_next;
        cnt   <= word_done ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - directed self-checking bench for serial_rx
module tb_serial_rx;
  import serial_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       transmission;
  logic       clock;
  logic       data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  int tests  = 0;
  int failed = 0;

  int         valid_cnt = 0;
  int         err_cnt   = 0;
  logic [7:0] cap [0:15];

  serial_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .transmission(transmission), .clock(clock),
    .data(data), .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      cap[valid_cnt % 16] = rx_data;
      valid_cnt = valid_cnt + 1;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    clock = 1'b0;
    data  = b;
    wait_clk(4);
    clock = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic end_frame();
    clock = 1'b0;
    transmission = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_reset();
    int v0, e0;
    rst = 1'b0; transmission = 1'b0; clock = 1'b0; data = 1'b0;
    wait_clk(3);
    tests++; if (rx_data !== 8'h00)  begin failed++; $display("FAIL por_rx_data got %h want 00", rx_data); end
    tests++; if (rx_valid !== 1'b0)  begin failed++; $display("FAIL por_rx_valid got %b want 0", rx_valid); end
    tests++; if (frame_err !== 1'b0) begin failed++; $display("FAIL por_frame_err got %b want 0", frame_err); end
    rst = 1'b1;
    wait_clk(4);
    v0 = valid_cnt; e0 = err_cnt;
    transmission = 1'b1;
    wait_clk(4);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    clock = 1'b0;
    rst = 1'b0;
    transmission = 1'b0;
    wait_clk(3);
    rst = 1'b1;
    wait_clk(8);
    tests++; if (rx_data !== 8'h00)     begin failed++; $display("FAIL rst_mid_rx_data got %h want 00", rx_data); end
    tests++; if (valid_cnt - v0 !== 0)  begin failed++; $display("FAIL rst_mid_valid got %0d want 0", valid_cnt - v0); end
    tests++; if (err_cnt - e0 !== 0)    begin failed++; $display("FAIL rst_mid_err got %0d want 0", err_cnt - e0); end
    tests++; if (dut.state !== IDLE)    begin failed++; $display("FAIL rst_mid_state got %0d want IDLE", dut.state); end
  endtask

  task automatic test_single();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    transmission = 1'b1;
    wait_clk(4);
    send_byte(8'hA5);
    end_frame();
    tests++; if (valid_cnt - v0 !== 1)      begin failed++; $display("FAIL a5_valid got %0d want 1", valid_cnt - v0); end
    tests++; if (cap[v0 % 16] !== 8'hA5)    begin failed++; $display("FAIL a5_data got %h want a5", cap[v0 % 16]); end
    tests++; if (rx_data !== 8'hA5)         begin failed++; $display("FAIL a5_hold got %h want a5", rx_data); end
    tests++; if (err_cnt - e0 !== 0)        begin failed++; $display("FAIL a5_err got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    transmission = 1'b1;
    wait_clk(4);
    send_byte(8'h3C);
    send_byte(8'hC3);
    end_frame();
    tests++; if (valid_cnt - v0 !== 2)          begin failed++; $display("FAIL b2b_valid got %0d want 2", valid_cnt - v0); end
    tests++; if (cap[v0 % 16] !== 8'h3C)        begin failed++; $display("FAIL b2b_first got %h want 3c", cap[v0 % 16]); end
    tests++; if (cap[(v0 + 1) % 16] !== 8'hC3)  begin failed++; $display("FAIL b2b_second got %h want c3", cap[(v0 + 1) % 16]); end
    tests++; if (err_cnt - e0 !== 0)            begin failed++; $display("FAIL b2b_err got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_truncated();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    transmission = 1'b1;
    wait_clk(4);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    end_frame();
    tests++; if (err_cnt - e0 !== 1)    begin failed++; $display("FAIL trunc_err got %0d want 1", err_cnt - e0); end
    tests++; if (valid_cnt - v0 !== 0)  begin failed++; $display("FAIL trunc_valid got %0d want 0", valid_cnt - v0); end
    tests++; if (rx_data !== 8'hC3)     begin failed++; $display("FAIL trunc_hold got %h want c3", rx_data); end
    tests++; if (dut.state !== IDLE)    begin failed++; $display("FAIL trunc_state got %0d want IDLE", dut.state); end
  endtask

  task automatic test_coincident_fall();
    int v0, e0;
    logic [7:0] w;
    w = 8'h5A;
    v0 = valid_cnt; e0 = err_cnt;
    transmission = 1'b1;
    wait_clk(4);
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    clock = 1'b0;
    data  = w[0];
    wait_clk(4);
    clock = 1'b1;
    transmission = 1'b0;
    wait_clk(8);
    clock = 1'b0;
    wait_clk(4);
    tests++; if (err_cnt - e0 !== 1)    begin failed++; $display("FAIL coinc_err got %0d want 1", err_cnt - e0); end
    tests++; if (valid_cnt - v0 !== 0)  begin failed++; $display("FAIL coinc_valid got %0d want 0", valid_cnt - v0); end
    tests++; if (rx_data !== 8'hC3)     begin failed++; $display("FAIL coinc_hold got %h want c3", rx_data); end
  endtask

`ifdef SERIAL_RX_PARITY_EN
  task automatic test_parity();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    transmission = 1'b1;
    wait_clk(4);
    send_byte(8'h07);
    send_bit(1'b1);
    end_frame();
    tests++; if (valid_cnt - v0 !== 1)      begin failed++; $display("FAIL par_ok_valid got %0d want 1", valid_cnt - v0); end
    tests++; if (rx_data !== 8'h07)         begin failed++; $display("FAIL par_ok_data got %h want 07", rx_data); end
    tests++; if (err_cnt - e0 !== 0)        begin failed++; $display("FAIL par_ok_err got %0d want 0", err_cnt - e0); end
    v0 = valid_cnt; e0 = err_cnt;
    transmission = 1'b1;
    wait_clk(4);
    send_byte(8'h07);
    send_bit(1'b0);
    end_frame();
    tests++; if (valid_cnt - v0 !== 0)      begin failed++; $display("FAIL par_bad_valid got %0d want 0", valid_cnt - v0); end
    tests++; if (err_cnt - e0 !== 1)        begin failed++; $display("FAIL par_bad_err got %0d want 1", err_cnt - e0); end
    tests++; if (rx_data !== 8'h07)         begin failed++; $display("FAIL par_bad_hold got %h want 07", rx_data); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef SERIAL_RX_PARITY_EN
    test_parity();
`else
    test_single();
    test_back_to_back();
    test_truncated();
    test_coincident_fall();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
